// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles 19-bit words from a byte stream, writes them
// from address 0 upward, and holds the core in reset until the program is in place.
module imem_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [18:0]       mem_wdata,
    output logic              core_rst,
    output logic              init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN0   = 3'd1,
        LEN1   = 3'd2,
        W0     = 3'd3,
        W1     = 3'd4,
        W2     = 3'd5,
        FINISH = 3'd6,
        ABORT  = 3'd7
    } state_t;

    // Largest legal word count; the index is one bit wider so it can reach it.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    function automatic logic [18:0] assemble_word(input logic [7:0] b2,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b0);
        return {b2[2:0], b1, b0};
    endfunction

    state_t            state_r, next_state_s;
    logic [15:0]       len_r;
    logic [7:0]        b0_r, b1_r;
    logic [ADDR_W:0]   idx_r;
    logic              in_ready_r, busy_r, init_r, mem_we_r, core_rst_r, done_r, err_r;
    logic              in_ready_s, busy_s, init_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [18:0]       mem_wdata_r;
    logic              xfer_s, pad_ok_s;
    logic [16:0]       len_full_s, idx_inc_s;

    assign xfer_s     = in_valid && in_ready_r;
    assign pad_ok_s   = (in_data[7:3] == 5'd0);
    assign len_full_s = {1'b0, in_data, len_r[7:0]};
    assign idx_inc_s  = 17'(idx_r) + 17'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; every byte state advances only on a transfer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LEN0;
                else       next_state_s = IDLE;
            end
            LEN0: begin
                if (xfer_s) next_state_s = LEN1;
                else        next_state_s = LEN0;
            end
            LEN1: begin
                if (!xfer_s)                     next_state_s = LEN1;
                else if (len_full_s == 17'd0)    next_state_s = FINISH;
                else if (len_full_s > CAPACITY)  next_state_s = ABORT;
                else                             next_state_s = W0;
            end
            W0: begin
                if (xfer_s) next_state_s = W1;
                else        next_state_s = W0;
            end
            W1: begin
                if (xfer_s) next_state_s = W2;
                else        next_state_s = W1;
            end
            W2: begin
                if (!xfer_s)                             next_state_s = W2;
                else if (!pad_ok_s)                      next_state_s = ABORT;
                else if (idx_inc_s == {1'b0, len_r})     next_state_s = FINISH;
                else                                     next_state_s = W0;
            end
            FINISH:  next_state_s = IDLE;
            ABORT:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags can be registered.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        init_s     = 1'b0;
        case (next_state_s)
            LEN0, LEN1, W0, W1, W2: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            FINISH: begin
                busy_s = 1'b1;
                init_s = 1'b1;
            end
            ABORT:   busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Datapath, write port and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            init_r      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 19'd0;
            core_rst_r  <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            len_r       <= 16'd0;
            b0_r        <= 8'd0;
            b1_r        <= 8'd0;
            idx_r       <= '0;
        end else begin
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
            init_r     <= init_s;
            mem_we_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        core_rst_r <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        idx_r      <= '0;
                    end
                end
                LEN0: if (xfer_s) len_r[7:0] <= in_data;
                LEN1: begin
                    if (xfer_s) begin
                        len_r[15:8] <= in_data;
                        if (next_state_s == ABORT) err_r <= 1'b1;
                    end
                end
                W0: if (xfer_s) b0_r <= in_data;
                W1: if (xfer_s) b1_r <= in_data;
                W2: begin
                    if (xfer_s && pad_ok_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= idx_r[ADDR_W-1:0];
                        mem_wdata_r <= assemble_word(in_data, b1_r, b0_r);
                        idx_r       <= idx_r + (ADDR_W+1)'(1);
                    end else if (xfer_s) begin
                        err_r <= 1'b1;
                    end
                end
                FINISH: begin
                    core_rst_r <= 1'b0;
                    done_r     <= 1'b1;
                end
                ABORT:   core_rst_r <= 1'b1;
                default: core_rst_r <= 1'b1;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign init      = init_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign core_rst  = core_rst_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
